// File: rtl/hazard_scoreboard.sv
// ID-stage interlock: scoreboard of in-flight writes plus mul/div busy counter; stall is combinational from state.
// id_stall holds IF/ID, and holding is the only backpressure. A flush clears all state the next cycle.
module hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int NUM_ENT = 4,
    parameter int LAT_W   = 2,
    parameter int MD_W    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NUM_SRC*5-1:0] id_src_flat,
    input  logic [NUM_SRC-1:0]   id_src_use,
    input  logic                 id_reads_hilo,
    input  logic [4:0]           id_dst,
    input  logic [LAT_W-1:0]     id_dst_lat,
    input  logic                 id_md_start,
    input  logic [MD_W-1:0]      id_md_cycles,
    input  logic                 pipe_adv,
    input  logic                 flush,
    output logic                 id_stall,
    output logic [NUM_SRC-1:0]   src_stall,
    output logic                 sb_full,
    output logic                 hilo_busy
);

    localparam logic [LAT_W-1:0] CNT_ONE = 1;
    localparam logic [MD_W-1:0]  MD_ONE  = 1;

    logic [NUM_ENT-1:0] ent_vld;
    logic [4:0]         ent_dst [NUM_ENT];
    logic [LAT_W-1:0]   ent_cnt [NUM_ENT];
    logic [MD_W-1:0]    md_cnt;

    logic               need_alloc;
    logic               id_fire;
    logic               alloc_en;
    logic [NUM_ENT-1:0] alloc_oh;
    logic               alloc_found;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [4:0]         src;
        logic [NUM_ENT-1:0] hit_vec;
        assign src = id_src_flat[5*i +: 5];
        for (genvar e = 0; e < NUM_ENT; e++) begin : g_hit
            assign hit_vec[e] = ent_vld[e] && (ent_dst[e] == src);
        end
        // $0 is hardwired zero, so it never carries a hazard
        assign src_stall[i] = id_valid && id_src_use[i] && (src != 5'd0) && (|hit_vec);
    end

    assign sb_full    = &ent_vld;
    assign hilo_busy  = (md_cnt != '0);
    assign need_alloc = (id_dst != 5'd0) && (id_dst_lat != '0);

    assign id_stall = (|src_stall)
                    | (id_valid && need_alloc && sb_full)
                    | (id_valid && (id_reads_hilo || id_md_start) && hilo_busy);

    assign id_fire  = id_valid && !id_stall && !flush;
    assign alloc_en = id_fire && need_alloc;

    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int e = 0; e < NUM_ENT; e++) begin
            if (!ent_vld[e] && !alloc_found) begin
                alloc_oh[e] = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_vld <= '0;
            md_cnt  <= '0;
            for (int e = 0; e < NUM_ENT; e++) begin
                ent_dst[e] <= 5'd0;
                ent_cnt[e] <= '0;
            end
        end else if (flush) begin
            ent_vld <= '0;
            md_cnt  <= '0;
            for (int e = 0; e < NUM_ENT; e++) begin
                ent_cnt[e] <= '0;
            end
        end else begin
            for (int e = 0; e < NUM_ENT; e++) begin
                if (alloc_en && alloc_oh[e]) begin
                    ent_vld[e] <= 1'b1;
                    ent_dst[e] <= id_dst;
                    ent_cnt[e] <= id_dst_lat;
                end else if (ent_vld[e] && pipe_adv) begin
                    // an allocated entry always has cnt >= 1, so 1->0 retires it
                    ent_cnt[e] <= ent_cnt[e] - CNT_ONE;
                    if (ent_cnt[e] == CNT_ONE) begin
                        ent_vld[e] <= 1'b0;
                    end
                end
            end
            if (id_fire && id_md_start) begin
                md_cnt <= id_md_cycles;
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - MD_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard at default parameters; expectations hand-derived from cycle timelines.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_src_flat;
    logic [1:0]  id_src_use;
    logic        id_reads_hilo;
    logic [4:0]  id_dst;
    logic [1:0]  id_dst_lat;
    logic        id_md_start;
    logic [5:0]  id_md_cycles;
    logic        pipe_adv;
    logic        flush;
    logic        id_stall;
    logic [1:0]  src_stall;
    logic        sb_full;
    logic        hilo_busy;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard #(.NUM_SRC(2), .NUM_ENT(4), .LAT_W(2), .MD_W(6)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_flat(id_src_flat),
        .id_src_use(id_src_use), .id_reads_hilo(id_reads_hilo), .id_dst(id_dst),
        .id_dst_lat(id_dst_lat), .id_md_start(id_md_start), .id_md_cycles(id_md_cycles),
        .pipe_adv(pipe_adv), .flush(flush), .id_stall(id_stall), .src_stall(src_stall),
        .sb_full(sb_full), .hilo_busy(hilo_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] use_b, input logic hl, input logic [4:0] d,
                          input logic [1:0] lat, input logic mds, input logic [5:0] mdc);
        id_valid      = v;
        id_src_flat   = {s1, s0};
        id_src_use    = use_b;
        id_reads_hilo = hl;
        id_dst        = d;
        id_dst_lat    = lat;
        id_md_start   = mds;
        id_md_cycles  = mdc;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b0, 6'd0);
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        pipe_adv = 1'b1;
        idle();
        cyc(); cyc();
        reset = 1'b0;
        settle();
        chk("rst_stall", {7'd0, id_stall}, 8'd0);
        chk("rst_src", {6'd0, src_stall}, 8'd0);
        chk("rst_full", {7'd0, sb_full}, 8'd0);
        chk("rst_hilo", {7'd0, hilo_busy}, 8'd0);
        set_id(1'b1, 5'd8, 5'd9, 2'b11, 1'b1, 5'd3, 2'd0, 1'b0, 6'd0);
        settle();
        chk("rst_read_nostall", {7'd0, id_stall}, 8'd0);

        // lw $8 lat1, then addu $9,$8,$0 directly behind
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd8, 2'd1, 1'b0, 6'd0);
        settle();
        chk("lw_fire", {7'd0, id_stall}, 8'd0);
        cyc();
        set_id(1'b1, 5'd8, 5'd0, 2'b11, 1'b0, 5'd9, 2'd0, 1'b0, 6'd0);
        settle();
        chk("lw_dep_t1", {7'd0, id_stall}, 8'd1);
        chk("lw_src_t1", {6'd0, src_stall}, 8'h01);
        cyc(); settle();
        chk("lw_dep_t2", {7'd0, id_stall}, 8'd0);
        chk("lw_src_t2", {6'd0, src_stall}, 8'h00);

        // mfc0 $4 lat2 with a pipe freeze at t1
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd4, 2'd2, 1'b0, 6'd0);
        cyc();
        set_id(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd6, 2'd0, 1'b0, 6'd0);
        pipe_adv = 1'b0;
        settle();
        chk("mfc0f_t1", {7'd0, id_stall}, 8'd1);
        cyc(); pipe_adv = 1'b1; settle();
        chk("mfc0f_t2", {7'd0, id_stall}, 8'd1);
        cyc(); settle();
        chk("mfc0f_t3", {7'd0, id_stall}, 8'd1);
        cyc(); settle();
        chk("mfc0f_t4", {7'd0, id_stall}, 8'd0);

        // mfc0 $4 lat2 with the pipe advancing throughout
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd4, 2'd2, 1'b0, 6'd0);
        cyc();
        set_id(1'b1, 5'd0, 5'd4, 2'b10, 1'b0, 5'd6, 2'd0, 1'b0, 6'd0);
        settle();
        chk("mfc0_t1", {7'd0, id_stall}, 8'd1);
        chk("mfc0_src_t1", {6'd0, src_stall}, 8'h02);
        cyc(); settle();
        chk("mfc0_t2", {7'd0, id_stall}, 8'd1);
        cyc(); settle();
        chk("mfc0_t3", {7'd0, id_stall}, 8'd0);

        // fill all four entries with a frozen pipe, then a fifth writer
        pipe_adv = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            cyc();
            set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'(r), 2'd3, 1'b0, 6'd0);
            settle();
            chk("fill_nostall", {7'd0, id_stall}, 8'd0);
        end
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd3, 1'b0, 6'd0);
        settle();
        chk("full_flag", {7'd0, sb_full}, 8'd1);
        chk("full_dst0", {7'd0, id_stall}, 8'd0);
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 2'd0, 1'b0, 6'd0);
        settle();
        chk("full_read0", {7'd0, id_stall}, 8'd0);
        set_id(1'b1, 5'd0, 5'd3, 2'b10, 1'b0, 5'd0, 2'd0, 1'b0, 6'd0);
        settle();
        chk("full_read3_src", {6'd0, src_stall}, 8'h02);
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 2'd3, 1'b0, 6'd0);
        settle();
        chk("full_stall_t4", {7'd0, id_stall}, 8'd1);
        cyc(); pipe_adv = 1'b1; settle();
        chk("full_stall_t5", {7'd0, id_stall}, 8'd1);
        cyc(); settle();
        chk("full_stall_t6", {7'd0, id_stall}, 8'd1);
        cyc(); settle();
        chk("full_stall_t7", {7'd0, id_stall}, 8'd1);
        chk("full_flag_t7", {7'd0, sb_full}, 8'd1);
        cyc(); settle();
        chk("full_free_t8", {7'd0, sb_full}, 8'd0);
        chk("full_stall_t8", {7'd0, id_stall}, 8'd0);
        cyc();
        set_id(1'b1, 5'd0, 5'd5, 2'b10, 1'b0, 5'd0, 2'd0, 1'b0, 6'd0);
        settle();
        chk("dep5_src", {6'd0, src_stall}, 8'h02);
        idle();
        cyc(); cyc(); cyc(); cyc();

        // div of 35 cycles, mflo behind it, second div at t5
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b1, 6'd35);
        settle();
        chk("div_fire", {7'd0, id_stall}, 8'd0);
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd2, 2'd0, 1'b0, 6'd0);
        settle();
        chk("div_busy_t1", {7'd0, hilo_busy}, 8'd1);
        for (int t = 1; t <= 35; t++) begin
            if (t == 5) begin
                set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b1, 6'd35);
                settle();
                chk("div2_stall_t5", {7'd0, id_stall}, 8'd1);
                set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd2, 2'd0, 1'b0, 6'd0);
            end
            settle();
            chk("mflo_stall", {7'd0, id_stall}, 8'd1);
            cyc();
        end
        settle();
        chk("mflo_t36", {7'd0, id_stall}, 8'd0);
        chk("hilo_t36", {7'd0, hilo_busy}, 8'd0);

        // md_cycles=0 gives no busy period
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b1, 6'd0);
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd2, 2'd0, 1'b0, 6'd0);
        settle();
        chk("md0_busy", {7'd0, hilo_busy}, 8'd0);
        chk("md0_stall", {7'd0, id_stall}, 8'd0);

        // flush with three valid entries, md busy and an allocating ID instr
        cyc();
        pipe_adv = 1'b0;
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd10, 2'd3, 1'b1, 6'd20);
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd11, 2'd3, 1'b0, 6'd0);
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd12, 2'd3, 1'b0, 6'd0);
        cyc();
        set_id(1'b1, 5'd11, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0, 6'd0);
        settle();
        chk("pre_flush_dep", {7'd0, id_stall}, 8'd1);
        chk("pre_flush_hilo", {7'd0, hilo_busy}, 8'd1);
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd13, 2'd3, 1'b0, 6'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        settle();
        chk("flush_full", {7'd0, sb_full}, 8'd0);
        chk("flush_hilo", {7'd0, hilo_busy}, 8'd0);
        set_id(1'b1, 5'd13, 5'd10, 2'b11, 1'b1, 5'd0, 2'd0, 1'b0, 6'd0);
        settle();
        chk("flush_src", {6'd0, src_stall}, 8'h00);
        chk("flush_stall", {7'd0, id_stall}, 8'd0);
        pipe_adv = 1'b1;

        // reset in the middle of a countdown
        cyc();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 5'd7, 2'd3, 1'b1, 6'd10);
        cyc();
        set_id(1'b1, 5'd7, 5'd0, 2'b01, 1'b1, 5'd0, 2'd0, 1'b0, 6'd0);
        settle();
        chk("pre_rst_stall", {7'd0, id_stall}, 8'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        chk("post_rst_stall", {7'd0, id_stall}, 8'd0);
        chk("post_rst_src", {6'd0, src_stall}, 8'h00);
        chk("post_rst_hilo", {7'd0, hilo_busy}, 8'd0);
        chk("post_rst_full", {7'd0, sb_full}, 8'd0);

        idle();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
